apu_frame_sequencer: RTL and testbench
======================================

# apu_frame_sequencer

Generates the APU's low-rate housekeeping strobes (length, sweep, envelope) from the DIV-derived 512 Hz level. It sits between the timer's DIV tap and the four sound channels, alongside the NR50/NR51/NR52 control logic. It is held in reset while the APU is powered off (NR52 bit 7 = 0), so every power-on restarts the 8-step schedule at step 0.

## Interface
Parameters:
- STEPS, 8, number of sequencer steps per frame (fixed; power of two)

Ports:
- apuv_4mhz  in  1  APU clock, all state on rising edge
- apu_reset  in  1  reset, asynchronous, active-high (APU power off)
- div_apu  in  1  512 Hz DIV tap level; a falling edge requests one step
- t1_nt2  in  1  test mode select; 1 = steps driven by test_step
- test_step  in  1  test mode: each cycle high executes one step
- len_tick  out  1  one-cycle strobe, clock length counters (steps 0,2,4,6)
- sweep_tick  out  1  one-cycle strobe, clock ch1 sweep (steps 2,6)
- env_tick  out  1  one-cycle strobe, clock envelopes (step 7)
- fs_next  out  3  index of next step to execute
- len_quiet  out  1  =fs_next[0]; next step does not clock length (NRx4 extra-length-clock rule)

## Operation
- Step request, normal mode (t1_nt2=0): registered sample div_q; request when div_q=1 and div_apu=0.
- Step request, test mode (t1_nt2=1): request every cycle test_step=1; div_apu ignored, div_q still tracks it.
- Mode switch while div_q=1, div_apu=0: no request from the stale edge in the cycle after returning to normal mode. The edge detector compares only samples taken while in normal mode.
- On an executed request, at step s=fs_next:
  - len_tick = (s even)
  - sweep_tick = (s==2 or s==6)
  - env_tick = (s==7)
  - fs_next <= s+1 mod 8, wrapping 7 -> 0
- No request: all strobes 0; fs_next holds.
- Strobes are mutually consistent per step. At most one step per cycle. Strobes are never stretched or queued.
- Reset values: fs_next=0, len_quiet=0, len_tick=0, sweep_tick=0, env_tick=0, div_q=0.
- Reset mid-frame: in-flight strobe is dropped immediately (asynchronous clear). The first step after release is step 0.

## Timing
- Request detected in cycle N -> strobes high for exactly cycle N+1. fs_next shows s+1 from cycle N+1.
- Latency from div_apu falling to strobe: 1 cycle after div_q captures 1 and div_apu reads 0 (total 1-2 cycles, depending on sample phase).
- First cycle after reset release: div_q=0, so no request in that cycle even if div_apu=0.
- Back-to-back test_step: one step per cycle. 8 consecutive cycles produce exactly one full frame.

## Configuration
Macro: APU_FS_POWERON_SKIP_EN
- Defined:
  - A skip_arm flag is set by reset.
  - In the first cycle after release, skip_arm stays set if div_apu=1; otherwise it clears.
  - While skip_arm is set, the next normal-mode request is swallowed: no strobes, fs_next unchanged, and skip_arm clears.
  - Test-mode requests are never swallowed; any test-mode request clears skip_arm.
- Undefined: no skip_arm flag; every request executes.

## Structure
- Shared package apu_pkg:
  - APU_FS_STEPS=8
  - typedef logic [2:0] apu_fs_step_t
  - step masks APU_FS_LEN_MASK=8'b0101_0101, APU_FS_SWEEP_MASK=8'b0100_0100, APU_FS_ENV_MASK=8'b1000_0000 (bit s = step s)
- Sub-module apu_fs_edge:
  - contains div_q, the mode-aware request mux and the optional skip_arm
  - outputs a single step_req
- The top level holds the step counter and the registered strobes decoded from the package masks.

## Test plan
- Reset, then 8 div_apu falling edges (period 8192 cycles) -> len_tick on edges 1,3,5,7; sweep_tick on 3,7; env_tick on 8; fs_next returns to 0.
- Reset, then 10 edges -> edge 9 strobes len_tick only (step 0 after wrap); edge 10 strobes nothing and leaves fs_next=2, len_quiet=0.
- t1_nt2=1, test_step held high 16 cycles -> strobe pattern repeats twice at one step per cycle; div_apu toggling in that window has no effect.
- apu_reset pulsed at fs_next=5 -> all outputs 0 asynchronously; next edge after release produces len_tick with fs_next 0->1.
- With APU_FS_POWERON_SKIP_EN, release reset with div_apu=1 -> first falling edge produces no strobes and fs_next stays 0; second edge strobes len_tick. Release with div_apu=0 -> first edge strobes len_tick.
- Check len_quiet = fs_next[0] after every step; strobes are one cycle wide and occur only in cycles following a request.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU definitions: frame sequencer step type, per-step strobe masks
// and the decode helper that turns a step index into its strobe set.
package apu_pkg;

    localparam int APU_FS_STEPS = 8;

    typedef logic [2:0] apu_fs_step_t;

    // Bit s of each mask is set when step s fires that strobe.
    localparam logic [7:0] APU_FS_LEN_MASK   = 8'b0101_0101;
    localparam logic [7:0] APU_FS_SWEEP_MASK = 8'b0100_0100;
    localparam logic [7:0] APU_FS_ENV_MASK   = 8'b1000_0000;

    typedef struct packed {
        logic len;
        logic sweep;
        logic env;
    } apu_fs_strobe_t;

    function automatic apu_fs_strobe_t apu_fs_decode(input apu_fs_step_t step);
        apu_fs_strobe_t s;
        s.len   = APU_FS_LEN_MASK[step];
        s.sweep = APU_FS_SWEEP_MASK[step];
        s.env   = APU_FS_ENV_MASK[step];
        return s;
    endfunction

endpackage

// File: rtl/apu_frame_sequencer_if.sv
// Signal bundle between the DIV/test-mode sources and the frame sequencer.
// master: the side driving the step sources and consuming the strobes.
// slave:  the frame sequencer itself.
interface apu_frame_sequencer_if;
    import apu_pkg::*;

    logic         div_apu;
    logic         t1_nt2;
    logic         test_step;
    logic         len_tick;
    logic         sweep_tick;
    logic         env_tick;
    apu_fs_step_t fs_next;
    logic         len_quiet;

    modport master (
        output div_apu, t1_nt2, test_step,
        input  len_tick, sweep_tick, env_tick, fs_next, len_quiet
    );

    modport slave (
        input  div_apu, t1_nt2, test_step,
        output len_tick, sweep_tick, env_tick, fs_next, len_quiet
    );

endinterface

// File: rtl/apu_fs_edge.sv
// Step request generator: samples the 512 Hz DIV level, detects its falling
// edge in normal mode, or passes test_step through in test mode.
// Optional feature macro: APU_FS_POWERON_SKIP_EN -- swallows the first
// normal-mode request after power-on when DIV was high at release.
module apu_fs_edge (
    input  logic clk,
    input  logic rst,
    input  logic div_apu,
    input  logic t1_nt2,
    input  logic test_step,
    output logic step_req
);

    logic div_q;    // previous div_apu sample
    logic norm_q;   // previous cycle was normal mode, so div_q is a valid edge reference
    logic test_req;
    logic norm_req;

    // Sample DIV every cycle and remember which mode the sample was taken in.
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q  <= 1'b0;
            norm_q <= 1'b0;
        end else begin
            div_q  <= div_apu;
            norm_q <= ~t1_nt2;
        end
    end

    // Mode-aware request mux; a stale test-mode sample never forms an edge.
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    always_comb begin
        test_req = 1'b0;
        norm_req = 1'b0;
        if (t1_nt2) begin
            test_req = test_step;
        end else begin
            norm_req = norm_q & div_q & ~div_apu;
        end
    end

`ifdef APU_FS_POWERON_SKIP_EN
    logic skip_arm;
    logic first_q;  // high only in the first cycle after reset release

    // Arm the power-on skip from the DIV level at release; disarm on use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skip_arm <= 1'b1;
            first_q  <= 1'b1;
        end else begin
            first_q <= 1'b0;
            if (test_req) begin
                skip_arm <= 1'b0;
            end else if (first_q) begin
                skip_arm <= div_apu;
            end else if (norm_req) begin
                skip_arm <= 1'b0;
            end
        end
    end

    assign step_req = test_req | (norm_req & ~skip_arm);
`else
    assign step_req = test_req | norm_req;
`endif

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: advances an 8-step schedule once per step request
// and emits one-cycle length/sweep/envelope strobes for the executed step.
// Optional feature macro: APU_FS_POWERON_SKIP_EN (see apu_fs_edge).
module apu_frame_sequencer
    import apu_pkg::*;
#(
    parameter int STEPS = APU_FS_STEPS
) (
    input  logic                        apuv_4mhz,
    input  logic                        apu_reset,
    apu_frame_sequencer_if.slave        bus
);

    localparam apu_fs_step_t LAST_STEP = apu_fs_step_t'(STEPS - 1);

    logic           step_req;
    apu_fs_step_t   fs_q;
    apu_fs_strobe_t strobe_q;

    apu_fs_edge u_edge (
        .clk       (apuv_4mhz),
        .rst       (apu_reset),
        .div_apu   (bus.div_apu),
        .t1_nt2    (bus.t1_nt2),
        .test_step (bus.test_step),
        .step_req  (step_req)
    );

    // Execute the current step on a request: register its strobes and advance.
    always_ff @(posedge apuv_4mhz or posedge apu_reset) begin
        if (apu_reset) begin
            fs_q     <= '0;
            strobe_q <= '0;
        end else begin
            strobe_q <= step_req ? apu_fs_decode(fs_q) : '0;
            if (step_req) begin
                fs_q <= (fs_q == LAST_STEP) ? '0 : fs_q + 1'b1;
            end
        end
    end

    assign bus.len_tick   = strobe_q.len;
    assign bus.sweep_tick = strobe_q.sweep;
    assign bus.env_tick   = strobe_q.env;
    assign bus.fs_next    = fs_q;
    assign bus.len_quiet  = fs_q[0];

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed self-checking bench for apu_frame_sequencer. Inputs change on the
// falling clock edge; outputs are sampled on the falling edge as well.
// The power-on skip scenario follows APU_FS_POWERON_SKIP_EN.
module tb_apu_frame_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    apu_frame_sequencer_if bus ();

    apu_frame_sequencer dut (
        .apuv_4mhz (clk),
        .apu_reset (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Hand-written step table, independent of the RTL masks.
    function automatic logic exp_len(input int s);
        return (s % 2) == 0;
    endfunction
    function automatic logic exp_sweep(input int s);
        return (s == 2) || (s == 6);
    endfunction
    function automatic logic exp_env(input int s);
        return s == 7;
    endfunction

    // Hold reset for two cycles and release it with div_apu at the given level.
    task automatic do_reset(input logic div_level);
        rst = 1'b1;
        bus.div_apu   = div_level;
        bus.t1_nt2    = 1'b0;
        bus.test_step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One DIV period: 8 cycles high then 8 low; counts strobe cycles seen.
    task automatic pulse_div(output int nl, output int ns, output int ne, output int nq);
        nl = 0; ns = 0; ne = 0; nq = 0;
        for (int c = 0; c < 16; c++) begin
            bus.div_apu = (c < 8);
            @(negedge clk);
            if (bus.len_tick)   nl++;
            if (bus.sweep_tick) ns++;
            if (bus.env_tick)   ne++;
            if (bus.len_quiet !== bus.fs_next[0]) nq++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.div_apu = 1'b0; bus.t1_nt2 = 1'b0; bus.test_step = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.len_tick, bus.sweep_tick, bus.env_tick, bus.len_quiet} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes got %b want 0000",
                     {bus.len_tick, bus.sweep_tick, bus.env_tick, bus.len_quiet});
        end
        checks++;
        if (bus.fs_next !== 3'd0) begin
            errors++;
            $display("FAIL reset_fs_next got %0d want 0", bus.fs_next);
        end
        // Release with div_apu low: no request may appear while it stays low.
        @(negedge clk);
        rst = 1'b0;
        begin
            int n = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (bus.len_tick || bus.sweep_tick || bus.env_tick) n++;
            end
            checks++;
            if (n !== 0 || bus.fs_next !== 3'd0) begin
                errors++;
                $display("FAIL release_idle got strobes=%0d fs=%0d want 0 0", n, bus.fs_next);
            end
        end
    endtask

    // n_edges DIV falling edges from reset; each edge checked against the table.
    task automatic run_edges(input string tag, input int n_edges);
        int nl, ns, ne, nq;
        do_reset(1'b0);
        for (int k = 0; k < n_edges; k++) begin
            int s = k % 8;
            pulse_div(nl, ns, ne, nq);
            checks++;
            if (nl !== int'(exp_len(s)) || ns !== int'(exp_sweep(s)) || ne !== int'(exp_env(s))) begin
                errors++;
                $display("FAIL %s_strobes edge %0d got l%0d s%0d e%0d want l%0d s%0d e%0d",
                         tag, k + 1, nl, ns, ne, exp_len(s), exp_sweep(s), exp_env(s));
            end
            checks++;
            if (bus.fs_next !== 3'((s + 1) % 8)) begin
                errors++;
                $display("FAIL %s_fs edge %0d got %0d want %0d", tag, k + 1, bus.fs_next, (s + 1) % 8);
            end
            checks++;
            if (nq !== 0) begin
                errors++;
                $display("FAIL %s_len_quiet edge %0d got %0d bad cycles want 0", tag, k + 1, nq);
            end
        end
    endtask

    task automatic test_frame;
        run_edges("frame", 8);
    endtask

    // Edge 9 is step 0 again (len only); edge 10 is step 1 (nothing).
    task automatic test_wrap;
        run_edges("wrap", 10);
        checks++;
        if (bus.fs_next !== 3'd2 || bus.len_quiet !== 1'b0) begin
            errors++;
            $display("FAIL wrap_final got fs=%0d quiet=%b want fs=2 quiet=0", bus.fs_next, bus.len_quiet);
        end
    endtask

    task automatic test_back_to_back;
        int nl, ns, ne, nq;
        do_reset(1'b0);
        bus.t1_nt2 = 1'b1;
        bus.test_step = 1'b1;
        for (int j = 0; j < 16; j++) begin
            bus.div_apu = j[0];
            @(negedge clk);
            checks++;
            if (bus.len_tick !== exp_len(j % 8) || bus.sweep_tick !== exp_sweep(j % 8) ||
                bus.env_tick !== exp_env(j % 8) || bus.fs_next !== 3'((j + 1) % 8) ||
                bus.len_quiet !== 1'(((j + 1) % 8) % 2)) begin
                errors++;
                $display("FAIL b2b cycle %0d got l%b s%b e%b fs%0d q%b want l%b s%b e%b fs%0d",
                         j, bus.len_tick, bus.sweep_tick, bus.env_tick, bus.fs_next, bus.len_quiet,
                         exp_len(j % 8), exp_sweep(j % 8), exp_env(j % 8), (j + 1) % 8);
            end
        end
        bus.test_step = 1'b0;
        bus.div_apu = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.len_tick, bus.sweep_tick, bus.env_tick} !== 3'b000 || bus.fs_next !== 3'd0) begin
            errors++;
            $display("FAIL b2b_stop got strobes=%b fs=%0d want 000 0",
                     {bus.len_tick, bus.sweep_tick, bus.env_tick}, bus.fs_next);
        end
        // Stale edge: div_q captured 1 in test mode, div_apu low on return.
        bus.div_apu = 1'b1;
        @(negedge clk);
        bus.t1_nt2 = 1'b0;
        bus.div_apu = 1'b0;
        nl = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.len_tick || bus.sweep_tick || bus.env_tick) nl++;
        end
        checks++;
        if (nl !== 0 || bus.fs_next !== 3'd0) begin
            errors++;
            $display("FAIL stale_edge got strobes=%0d fs=%0d want 0 0", nl, bus.fs_next);
        end
        pulse_div(nl, ns, ne, nq);
        checks++;
        if (nl !== 1 || ns !== 0 || ne !== 0 || bus.fs_next !== 3'd1) begin
            errors++;
            $display("FAIL normal_resume got l%0d s%0d e%0d fs%0d want l1 s0 e0 fs1", nl, ns, ne, bus.fs_next);
        end
    endtask

    task automatic test_reset_mid;
        int nl, ns, ne, nq;
        do_reset(1'b0);
        for (int k = 0; k < 4; k++) pulse_div(nl, ns, ne, nq);
        bus.div_apu = 1'b1;
        for (int c = 0; c < 4; c++) @(negedge clk);
        bus.div_apu = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (bus.len_tick !== 1'b1 || bus.fs_next !== 3'd5) begin
            errors++;
            $display("FAIL mid_pre got len=%b fs=%0d want len=1 fs=5", bus.len_tick, bus.fs_next);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.len_tick, bus.sweep_tick, bus.env_tick, bus.len_quiet} !== 4'b0000 ||
            bus.fs_next !== 3'd0) begin
            errors++;
            $display("FAIL mid_async_clear got strobes=%b fs=%0d want 0000 0",
                     {bus.len_tick, bus.sweep_tick, bus.env_tick, bus.len_quiet}, bus.fs_next);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulse_div(nl, ns, ne, nq);
        checks++;
        if (nl !== 1 || ns !== 0 || ne !== 0 || bus.fs_next !== 3'd1) begin
            errors++;
            $display("FAIL mid_restart got l%0d s%0d e%0d fs%0d want l1 s0 e0 fs1", nl, ns, ne, bus.fs_next);
        end
    endtask

    task automatic test_poweron_skip;
        int nl, ns, ne, nq;
        // Release with DIV high.
        do_reset(1'b1);
        pulse_div(nl, ns, ne, nq);
`ifdef APU_FS_POWERON_SKIP_EN
        checks++;
        if (nl !== 0 || ns !== 0 || ne !== 0 || bus.fs_next !== 3'd0) begin
            errors++;
            $display("FAIL skip_first got l%0d s%0d e%0d fs%0d want l0 s0 e0 fs0", nl, ns, ne, bus.fs_next);
        end
        pulse_div(nl, ns, ne, nq);
`endif
        checks++;
        if (nl !== 1 || ns !== 0 || ne !== 0 || bus.fs_next !== 3'd1) begin
            errors++;
            $display("FAIL skip_high_exec got l%0d s%0d e%0d fs%0d want l1 s0 e0 fs1", nl, ns, ne, bus.fs_next);
        end
        // Release with DIV low: first edge always executes.
        do_reset(1'b0);
        pulse_div(nl, ns, ne, nq);
        checks++;
        if (nl !== 1 || ns !== 0 || ne !== 0 || bus.fs_next !== 3'd1) begin
            errors++;
            $display("FAIL skip_low_exec got l%0d s%0d e%0d fs%0d want l1 s0 e0 fs1", nl, ns, ne, bus.fs_next);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.div_apu = 1'b0;
        bus.t1_nt2 = 1'b0;
        bus.test_step = 1'b0;
        test_reset();
        test_frame();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        test_poweron_skip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
